tx_sched: RTL

TX_SCHED -- requirements
Module: tx_sched

---
 rtl/tx_sched.sv | 115 +++++++++++
 1 files changed

// File: rtl/tx_sched.sv
`default_nettype none
// ============================================================================
// tx_sched : round-robin scheduler for four requesters feeding one serialiser
// Revision : 1.0
// ============================================================================
`ifndef SIZE
`define SIZE 8
`endif

module tx_sched #(
  parameter int    routerid = -1,
  parameter string port     = "unknown"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [4*`SIZE-1:0]   data_in,
  input  logic                 en,
  input  logic                 tx_busy,
  output logic                 tx_req,
  output logic [`SIZE-1:0]     tx_data,
  output logic [3:0]           grant,
  output logic                 sched_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic             tx_req_q, tx_req_d;
  logic [`SIZE-1:0] tx_data_q, tx_data_d;
  logic [3:0]       grant_q, grant_d;

  logic [1:0]       cand;
  logic [1:0]       win_idx;
  logic             win_found;
  logic             start;

  // Search starts one past the previous winner, so the last winner comes last.
  always_comb begin
    cand      = '0;
    win_idx   = last_q;
    win_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign start = (state_q == S_IDLE) && en && win_found && !tx_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= 2'd3;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start)    state_d = S_ISSUE;
      S_ISSUE:  if (!tx_busy) state_d = S_SETTLE;
      S_SETTLE:               state_d = S_DRAIN;
      S_DRAIN:  if (!tx_busy) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_d    = last_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    grant_d   = '0;
    if (start) begin
      last_d           = win_idx;
      tx_req_d         = 1'b1;
      tx_data_d        = data_in[win_idx*`SIZE +: `SIZE];
      grant_d[win_idx] = 1'b1;
    end else if (state_q == S_ISSUE && !tx_busy) begin
      tx_req_d = 1'b0;
    end
  end

  assign tx_req     = tx_req_q;
  assign tx_data    = tx_data_q;
  assign grant      = grant_q;
  assign sched_busy = (state_q != S_IDLE);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && start && routerid > -1)
      $display("router %0d port %s: grant requester %0d flit %h",
               routerid, port, win_idx, data_in[win_idx*`SIZE +: `SIZE]);
  end
`endif

endmodule

`default_nettype wire
